ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL provide parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: Opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 SHALL provide port: zero  input  1  registered zero flag from the datapath.
REQ-006 SHALL provide port: start  input  1  leave IDLE and begin execution.
REQ-007 SHALL provide port: halt_req  input  1  debug request to stop after the current instruction.
REQ-008 SHALL provide port: step_req  input  1  execute exactly one instruction while HALTED.
REQ-009 SHALL provide port: resume  input  1  return from HALTED to RUN.
REQ-010 SHALL provide ports: s_inc, s_inm, we3, wez  output  1 each  datapath controls (s_inc=1 selects PC+1, s_inc=0 selects jump address).
REQ-011 SHALL provide port: ALUOp  output  3  ALU operation select.
REQ-012 SHALL provide port: pc_en  output  1  PC register load enable.
REQ-013 SHALL provide ports: running, halted, illegal  output  1 each  status.
REQ-014 SHALL provide port: icount  output  CNT_W  count of retired instructions.

Function
REQ-015 SHALL implement states IDLE, RUN, HALTED, STEP; an instruction "executes" only in a cycle where the state is RUN or STEP.
REQ-016 Decode SHALL be: Opcode[5]=1 -> ALU reg-reg (ALUOp=Opcode[4:2], s_inm=0, we3=1, wez=1); Opcode[5:2]=0000 -> load immediate (ALUOp=000, s_inm=1, we3=1, wez=0); 000100 J; 000101 JZ; 000110 JNZ; 000111 HALT; any other code -> NOP.
REQ-017 J SHALL drive s_inc=0; JZ SHALL drive s_inc=~zero; JNZ SHALL drive s_inc=zero; all other instructions SHALL drive s_inc=1.
REQ-018 Jumps, HALT and NOP SHALL drive we3=0 and wez=0.
REQ-019 In an executing cycle pc_en SHALL be 1 except for HALT, which SHALL drive pc_en=0, so PC stays on the HALT word.
REQ-020 In non-executing cycles pc_en, we3 and wez SHALL be 0, s_inc=1, s_inm=0 and ALUOp=000.
REQ-021 IDLE SHALL move to RUN on the edge where start=1; other debug inputs SHALL be ignored in IDLE.
REQ-022 RUN SHALL move to HALTED when the executing instruction is HALT or when halt_req=1; the instruction in that cycle SHALL still complete (single-cycle latency to stop).
REQ-023 HALTED: resume=1 SHALL move to RUN; otherwise step_req=1 SHALL move to STEP; resume SHALL have priority over step_req.
REQ-024 STEP SHALL last exactly one cycle, execute one instruction, then return to HALTED regardless of halt_req, step_req or resume.
REQ-025 A held step_req SHALL produce one STEP per HALTED->STEP->HALTED round (one instruction per two cycles), not continuous execution.
REQ-026 icount SHALL increment by 1 on every executing cycle whose instruction is not HALT, and SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-027 illegal SHALL be set in any executing cycle whose Opcode decodes as undefined NOP (codes 001xxx and 01xxxx), and SHALL stay set until reset.
REQ-028 running SHALL be 1 exactly in RUN and STEP; halted SHALL be 1 exactly in HALTED.
REQ-029 Control outputs SHALL be combinational from state, Opcode and zero; state, icount and illegal SHALL be registered.

Reset
REQ-030 reset=1 SHALL immediately force: state IDLE, icount=0, illegal=0, running=0, halted=0, pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
REQ-031 Reset asserted mid-instruction or mid-STEP SHALL abort it with no write enables asserted after the reset edge; execution SHALL resume only after a new start.

Verification
REQ-032 Reset, start=1, Opcode=100100 -> RUN, ALUOp=001, we3=1, wez=1, s_inm=0, pc_en=1, icount=1 after the edge.
REQ-033 RUN, Opcode=000101 with zero=1 -> s_inc=0; the same with zero=0 -> s_inc=1; Opcode=000110 with zero=0 -> s_inc=0; we3=0 in all cases.
REQ-034 RUN, Opcode=000111 -> pc_en=0, halted=1 next cycle, icount unchanged; step_req=1 on HALT word -> one STEP with pc_en=0, back to HALTED.
REQ-035 HALTED, step_req and resume both 1 -> RUN (not STEP); HALTED, step_req held 6 cycles -> exactly 3 instructions retired.
REQ-036 CNT_W=4, icount=15, one ALU instruction -> icount=0; Opcode=010000 executed -> illegal=1 and held through later valid instructions until reset.

Source files
------------

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: instruction-level controller for a single-cycle datapath.
// It holds the run/debug state (IDLE, RUN, HALTED, STEP), decodes the
// 6-bit opcode into datapath controls, and counts retired instructions.
// Controls are combinational from state/Opcode/zero, so an asynchronous
// reset to IDLE removes every write enable at once.
module ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       ALUOp,
  output logic             pc_en,
  output logic             running,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_icount;
  logic             r_illegal;

  logic w_exec;
  logic w_is_halt;
  logic w_is_undef;

  // An instruction only executes while running freely or single-stepping.
  assign w_exec     = (r_state == S_RUN) || (r_state == S_STEP);
  // HALT retires nothing and freezes the PC on its own word.
  assign w_is_halt  = (Opcode == 6'b000111);
  // 001xxx and 01xxxx are unassigned codes that fall through as NOP.
  assign w_is_undef = ~Opcode[5] & (Opcode[4:3] != 2'b00);

  // Opcode decode into datapath controls; idle values outside executing cycles.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    ALUOp = 3'b000;
    pc_en = 1'b0;
    if (w_exec) begin
      pc_en = 1'b1;
      if (Opcode[5]) begin
        ALUOp = Opcode[4:2];
        we3   = 1'b1;
        wez   = 1'b1;
      end else if (Opcode[5:2] == 4'b0000) begin
        s_inm = 1'b1;
        we3   = 1'b1;
      end else begin
        case (Opcode)
          6'b000100: s_inc = 1'b0;
          6'b000101: s_inc = ~zero;
          6'b000110: s_inc = zero;
          6'b000111: pc_en = 1'b0;
          default:   s_inc = 1'b1;
        endcase
      end
    end
  end

  // State sequencing, retired-instruction counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_icount  <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_exec && !w_is_halt)
        r_icount <= r_icount + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_exec && w_is_undef)
        r_illegal <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start)
            r_state <= S_RUN;
        end
        S_RUN: begin
          // The current instruction still completes; stop takes effect next cycle.
          if (w_is_halt || halt_req)
            r_state <= S_HALTED;
        end
        S_HALTED: begin
          // resume wins over step_req.
          if (resume)
            r_state <= S_RUN;
          else if (step_req)
            r_state <= S_STEP;
        end
        S_STEP: begin
          // Always one instruction only; a held step_req re-arms via HALTED.
          r_state <= S_HALTED;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign running = w_exec;
  assign halted  = (r_state == S_HALTED);
  assign illegal = r_illegal;
  assign icount  = r_icount;

endmodule
